// File: rtl/i_cache_if.sv
// Fetch-side and memory-side handshake bundle for the instruction cache.
// master = IF stage plus mem_ctrl, slave = the cache itself.
interface i_cache_if;
  logic        jump_signal;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_inst_valid;
  logic [31:0] if_inst;
  logic        if_busy;
  logic        icache_needed;
  logic [31:0] icache_addr;
  logic        inst_available;
  logic [31:0] inst_icache;

  modport master (
    output jump_signal, if_req, if_pc, inst_available, inst_icache,
    input  if_inst_valid, if_inst, if_busy, icache_needed, icache_addr
  );

  modport slave (
    input  jump_signal, if_req, if_pc, inst_available, inst_icache,
    output if_inst_valid, if_inst, if_busy, icache_needed, icache_addr
  );
endinterface

// File: rtl/i_cache.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding
// miss to mem_ctrl; jump_signal abandons the miss.
module i_cache #(
  parameter int INDEX_BITS = 7
) (
  input logic      clk,
  input logic      rst,
  i_cache_if.slave bus
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                state;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];

  logic [INDEX_BITS-1:0] req_idx;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;
  logic                  fill;

  logic                  inst_valid_q;
  logic [31:0]           inst_q;
  logic                  busy_q;
  logic                  needed_q;
  logic [31:0]           addr_q;
  logic                  unused_low_bits;

  assign req_idx  = bus.if_pc[INDEX_BITS+1:2];
  assign req_tag  = bus.if_pc[31:INDEX_BITS+2];
  assign fill_idx = addr_q[INDEX_BITS+1:2];
  assign fill_tag = addr_q[31:INDEX_BITS+2];
  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  // A return during MISS always fills, even when a jump kills the forward.
  assign fill     = (state == MISS) && bus.inst_available;
  assign unused_low_bits = ^{bus.if_pc[1:0], addr_q[1:0]};

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus.inst_icache;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      valid        <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      busy_q       <= 1'b0;
      needed_q     <= 1'b0;
      addr_q       <= '0;
    end else begin
      inst_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.if_req && !bus.jump_signal) begin
            if (hit) begin
              inst_valid_q <= 1'b1;
              inst_q       <= data_mem[req_idx];
            end else begin
              addr_q   <= {bus.if_pc[31:2], 2'b00};
              needed_q <= 1'b1;
              busy_q   <= 1'b1;
              state    <= MISS;
            end
          end
        end
        MISS: begin
          if (bus.inst_available) begin
            valid[fill_idx] <= 1'b1;
            needed_q        <= 1'b0;
            busy_q          <= 1'b0;
            state           <= IDLE;
            if (!bus.jump_signal) begin
              inst_valid_q <= 1'b1;
              inst_q       <= bus.inst_icache;
            end
          end else if (bus.jump_signal) begin
            needed_q <= 1'b0;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_inst_valid = inst_valid_q;
  assign bus.if_inst       = inst_q;
  assign bus.if_busy       = busy_q;
  assign bus.icache_needed = needed_q;
  assign bus.icache_addr   = addr_q;
endmodule

// File: tb/tb_i_cache.sv
// Bench for i_cache: directed fetch table, hand sequences for kill/reset corners,
// then random fetches checked against a line-map model of the cache.
module tb_i_cache;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  i_cache_if bus();
  i_cache #(.INDEX_BITS(7)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Model: line index -> cached word address and data.
  logic [29:0] m_addr [int];
  logic [31:0] m_data [int];

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] data;
    int          delay;
    int          kill;      // 0 none, 1 jump before return, 2 jump with return
    logic        exp_hit;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vecs [12];

  function automatic int idx_of(logic [31:0] pc);
    return int'(pc[8:2]);
  endfunction

  function automatic logic model_hit(logic [31:0] pc);
    int i = idx_of(pc);
    return m_addr.exists(i) && (m_addr[i] == pc[31:2]);
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // Entered and left just after a falling edge.
  task automatic run_fetch(input logic [31:0] pc, input logic [31:0] data,
                           input int delay, input int kill,
                           input logic exp_hit, input logic [31:0] exp_inst);
    logic [31:0] aligned;
    aligned = {pc[31:2], 2'b00};
    bus.if_req = 1'b1;
    bus.if_pc = pc;
    bus.jump_signal = 1'b0;
    @(negedge clk);
    bus.if_req = 1'b0;
    bus.if_pc = $urandom;
    if (exp_hit) begin
      check("hit_valid", 32'(bus.if_inst_valid), 32'd1);
      check("hit_inst", bus.if_inst, exp_inst);
      check("hit_needed", 32'(bus.icache_needed), 32'd0);
      check("hit_busy", 32'(bus.if_busy), 32'd0);
      return;
    end
    check("miss_needed", 32'(bus.icache_needed), 32'd1);
    check("miss_addr", bus.icache_addr, aligned);
    check("miss_busy", 32'(bus.if_busy), 32'd1);
    check("miss_valid", 32'(bus.if_inst_valid), 32'd0);
    for (int i = 1; i < delay; i++) begin
      bus.if_req = 1'($urandom_range(0, 1));
      bus.if_pc = $urandom;
      @(negedge clk);
      check("wait_needed", 32'(bus.icache_needed), 32'd1);
      check("wait_addr", bus.icache_addr, aligned);
      check("wait_valid", 32'(bus.if_inst_valid), 32'd0);
    end
    bus.if_req = 1'b0;
    if (kill == 1) begin
      bus.jump_signal = 1'b1;
      @(negedge clk);
      bus.jump_signal = 1'b0;
      check("kill_needed", 32'(bus.icache_needed), 32'd0);
      check("kill_busy", 32'(bus.if_busy), 32'd0);
      check("kill_valid", 32'(bus.if_inst_valid), 32'd0);
      bus.inst_available = 1'b1;
      bus.inst_icache = data;
      @(negedge clk);
      bus.inst_available = 1'b0;
      check("late_valid", 32'(bus.if_inst_valid), 32'd0);
      check("late_needed", 32'(bus.icache_needed), 32'd0);
    end else begin
      bus.jump_signal = (kill == 2);
      bus.inst_available = 1'b1;
      bus.inst_icache = data;
      @(negedge clk);
      bus.jump_signal = 1'b0;
      bus.inst_available = 1'b0;
      bus.inst_icache = $urandom;
      if (kill == 2) begin
        check("both_valid", 32'(bus.if_inst_valid), 32'd0);
      end else begin
        check("fill_valid", 32'(bus.if_inst_valid), 32'd1);
        check("fill_inst", bus.if_inst, exp_inst);
      end
      check("fill_needed", 32'(bus.icache_needed), 32'd0);
      check("fill_busy", 32'(bus.if_busy), 32'd0);
      m_addr[idx_of(pc)] = pc[31:2];
      m_data[idx_of(pc)] = data;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    logic [31:0] data;
    logic        hp;
    int          k;

    vecs[0]  = '{"cold_0x10",    32'h10,  32'h00500093, 4, 0, 1'b0, 32'h00500093};
    vecs[1]  = '{"hit_0x12",     32'h12,  32'h0,        0, 0, 1'b1, 32'h00500093};
    vecs[2]  = '{"conflict_210", 32'h210, 32'h00A00113, 4, 0, 1'b0, 32'h00A00113};
    vecs[3]  = '{"evicted_0x10", 32'h10,  32'h00500093, 5, 0, 1'b0, 32'h00500093};
    vecs[4]  = '{"kill_0x20",    32'h20,  32'hDEADBEEF, 2, 1, 1'b0, 32'h0};
    vecs[5]  = '{"refetch_0x20", 32'h20,  32'h11111111, 4, 0, 1'b0, 32'h11111111};
    vecs[6]  = '{"both_0x30",    32'h30,  32'h00000013, 3, 2, 1'b0, 32'h0};
    vecs[7]  = '{"hit_0x30",     32'h30,  32'h0,        0, 0, 1'b1, 32'h00000013};
    vecs[8]  = '{"again_210",    32'h210, 32'h00A00113, 4, 0, 1'b0, 32'h00A00113};
    vecs[9]  = '{"cold_0x214",   32'h214, 32'hCAFEF00D, 1, 0, 1'b0, 32'hCAFEF00D};
    vecs[10] = '{"hit_0x20",     32'h20,  32'h0,        0, 0, 1'b1, 32'h11111111};
    vecs[11] = '{"hit_0x217",    32'h217, 32'h0,        0, 0, 1'b1, 32'hCAFEF00D};

    bus.jump_signal = 1'b0;
    bus.if_req = 1'b0;
    bus.if_pc = '0;
    bus.inst_available = 1'b0;
    bus.inst_icache = '0;

    #12;
    check("rst_valid", 32'(bus.if_inst_valid), 32'd0);
    check("rst_inst", bus.if_inst, 32'd0);
    check("rst_busy", 32'(bus.if_busy), 32'd0);
    check("rst_needed", 32'(bus.icache_needed), 32'd0);
    check("rst_addr", bus.icache_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_fetch(vecs[i].pc, vecs[i].data, vecs[i].delay, vecs[i].kill,
                vecs[i].exp_hit, vecs[i].exp_inst);
    end

    // Jump in IDLE drops the request even for a cached line.
    bus.if_req = 1'b1;
    bus.if_pc = 32'h30;
    bus.jump_signal = 1'b1;
    @(negedge clk);
    bus.if_req = 1'b0;
    bus.jump_signal = 1'b0;
    check("idle_jump_valid", 32'(bus.if_inst_valid), 32'd0);
    check("idle_jump_needed", 32'(bus.icache_needed), 32'd0);
    check("idle_jump_busy", 32'(bus.if_busy), 32'd0);

    for (int n = 0; n < 200; n++) begin
      pc = 32'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      data = $urandom;
      hp = model_hit(pc);
      k = $urandom_range(0, 9);
      run_fetch(pc, data, $urandom_range(1, 6), (k < 7) ? 0 : ((k < 9) ? 1 : 2),
                hp, hp ? m_data[idx_of(pc)] : data);
      if ($urandom_range(0, 4) == 0) begin
        bus.inst_available = 1'b1;
        bus.inst_icache = $urandom;
        @(negedge clk);
        bus.inst_available = 1'b0;
        check("stray_valid", 32'(bus.if_inst_valid), 32'd0);
        check("stray_needed", 32'(bus.icache_needed), 32'd0);
      end
    end

    // Asynchronous reset in the middle of a miss.
    bus.if_req = 1'b1;
    bus.if_pc = 32'h0000_0FC0;
    @(negedge clk);
    bus.if_req = 1'b0;
    check("pre_rst_needed", 32'(bus.icache_needed), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_valid", 32'(bus.if_inst_valid), 32'd0);
    check("async_inst", bus.if_inst, 32'd0);
    check("async_busy", 32'(bus.if_busy), 32'd0);
    check("async_needed", 32'(bus.icache_needed), 32'd0);
    check("async_addr", bus.icache_addr, 32'd0);
    m_addr.delete();
    m_data.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    hp = model_hit(32'h10);
    run_fetch(32'h10, 32'h00500093, 4, 0, hp, 32'h00500093);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
